// File: rtl/tm_readout_pkg.sv
// tm_readout_pkg: shared constants and FSM state type for the transaction-memory read-out engine.
package tm_readout_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/tm_readout_if.sv
// tm_readout_if: memory port-B read bus plus the valid/ready byte stream.
// master = read-out engine, slave = memory/downstream side.
interface tm_readout_if;
   import tm_readout_pkg::*;

   logic [ADDR_W-1:0] mem_addrb;
   logic              mem_renb;
   logic [DATA_W-1:0] mem_doutb;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output mem_addrb, mem_renb, out_data, out_valid, out_last,
      input  mem_doutb, out_ready
   );

   modport slave (
      input  mem_addrb, mem_renb, out_data, out_valid, out_last,
      output mem_doutb, out_ready
   );
endinterface

// File: rtl/tm_readout_skid.sv
// tm_readout_skid: 2-entry valid/ready output buffer with a last tag per entry.
// The producer guarantees it never pushes into a full buffer without a same-cycle pop.
module tm_readout_skid
   import tm_readout_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_push_last,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_pop,
   output logic [1:0]        o_occ
);
   logic [DATA_W-1:0] r_data [2];
   logic [1:0]        r_last;
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_occ;
   logic              w_pop;

   // head of the buffer drives the stream; it only moves on a handshake
   always_comb begin
      o_valid = (r_occ != 2'd0);
      w_pop   = o_valid && i_ready;
      o_data  = r_data[r_rd_ptr];
      o_last  = o_valid && r_last[r_rd_ptr];
      o_pop   = w_pop;
      o_occ   = r_occ;
   end

   // storage, pointers and occupancy
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_last    <= '0;
         r_rd_ptr  <= 1'b0;
         r_wr_ptr  <= 1'b0;
         r_occ     <= 2'd0;
      end else begin
         if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_last[r_wr_ptr] <= i_push_last;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
      end
   end
endmodule

// File: rtl/tm_readout.sv
// tm_readout: streams a wrapping address range of the transaction memory (port B,
// 1-cycle read latency) out on a valid/ready byte stream with a last flag.
// Optional build macro TM_READOUT_CHECKSUM_EN appends an XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for start; done may pulse here for a zero-length request
// READ  | issuing reads (and the checksum slot) as buffer credit allows
// DRAIN | everything issued; buffer emptying; leaves when done pulses
module tm_readout
   import tm_readout_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_count,
   output logic              o_busy,
   output logic              o_done,
   tm_readout_if.master      bus
);
   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_left;       // items still to issue (bytes, plus checksum slot)
   logic              r_pend;       // an item lands in the buffer at the end of this cycle
   logic              r_pend_last;
   logic              r_done;
   logic              w_accept;
   logic              w_issue;
   logic              w_issue_last;
   logic              w_rd;
   logic              w_pop;
   logic [1:0]        w_occ;
   logic [1:0]        w_committed;
   logic [DATA_W-1:0] w_push_data;
`ifdef TM_READOUT_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
   logic              r_pend_csum;
`endif

   // state register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start && (i_count != '0)) w_state_nxt = READ;
         READ:    if (w_issue_last)               w_state_nxt = DRAIN;
         DRAIN:   if (r_done)                     w_state_nxt = IDLE;
         default:                                 w_state_nxt = IDLE;
      endcase
   end

   // outputs and read-issue gating; credit counts the byte leaving this cycle as freed
   always_comb begin
      o_busy       = (r_state != IDLE);
      o_done       = r_done;
      w_accept     = (r_state == IDLE) && i_start;
      w_committed  = w_occ + {1'b0, r_pend} - {1'b0, w_pop};
      w_issue      = (r_state == READ) && (w_committed < 2'd2) && (r_left != '0);
      w_issue_last = w_issue && (r_left == CNT_W'(1));
`ifdef TM_READOUT_CHECKSUM_EN
      w_rd         = w_issue && !w_issue_last;
      w_push_data  = r_pend_csum ? r_csum : bus.mem_doutb;
`else
      w_rd         = w_issue;
      w_push_data  = bus.mem_doutb;
`endif
      bus.mem_renb  = w_rd;
      bus.mem_addrb = w_rd ? r_addr : '0;
   end

   // address/issue counters, in-flight tracking and the registered done pulse
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_addr      <= '0;
         r_left      <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_pend      <= w_issue;
         r_pend_last <= w_issue_last;
         r_done      <= (w_accept && (i_count == '0)) || (w_pop && bus.out_last);
         if (w_accept) begin
            r_addr <= i_base_addr;
`ifdef TM_READOUT_CHECKSUM_EN
            r_left <= i_count + CNT_W'(1);
`else
            r_left <= i_count;
`endif
         end else if (w_issue) begin
            r_left <= r_left - CNT_W'(1);
            if (w_rd) r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

`ifdef TM_READOUT_CHECKSUM_EN
   // running XOR of data bytes as they enter the buffer; last issue slot is the checksum
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_csum      <= '0;
         r_pend_csum <= 1'b0;
      end else begin
         r_pend_csum <= w_issue_last;
         if (w_accept)                    r_csum <= '0;
         else if (r_pend && !r_pend_csum) r_csum <= r_csum ^ bus.mem_doutb;
      end
   end
`endif

   tm_readout_skid u_skid (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (r_pend),
      .i_push_data (w_push_data),
      .i_push_last (r_pend_last),
      .i_ready     (bus.out_ready),
      .o_valid     (bus.out_valid),
      .o_data      (bus.out_data),
      .o_last      (bus.out_last),
      .o_pop       (w_pop),
      .o_occ       (w_occ)
   );
endmodule

// File: tb/tb_tm_readout.sv
// tb_tm_readout: randomized and directed transfers checked against a byte-list model.
module tb_tm_readout;
   import tm_readout_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  cnt;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] mem [DEPTH];
   int                n_checks = 0;
   int                n_errors = 0;

   tm_readout_if bus();

   tm_readout dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_base_addr (base),
      .i_count     (cnt),
      .o_busy      (busy),
      .o_done      (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // port-B memory with 1-cycle read latency
   always @(posedge clk) if (bus.mem_renb) bus.mem_doutb <= mem[bus.mem_addrb];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic ready_for(input int mode, input int cyc);
      if (mode == 1) return (cyc % 2) == 1;
      if (mode == 2) return ($urandom % 3) != 0;
      return 1'b1;
   endfunction

   // mode: 0 ready high, 1 toggling, 2 random; inj_cyc: cycle of a start while busy;
   // abort_after: apply reset once this many bytes were accepted (-1 = never)
   task automatic run_xfer(input int b, input int c, input int mode, input int inj_cyc, input int abort_after);
      int exp_q[$];
      int total, nacc, nissued, ndone, done_cyc, first_v, last_hs, outstanding;
      logic [7:0] csum, pd;
      logic pv, pr, pl, hs;
      csum = 8'h00;
      exp_q = {};
      for (int i = 0; i < c; i++) begin
         exp_q.push_back(int'(mem[(b + i) % DEPTH]));
         csum ^= mem[(b + i) % DEPTH];
      end
`ifdef TM_READOUT_CHECKSUM_EN
      if (c > 0) exp_q.push_back(int'(csum));
`endif
      total = exp_q.size();
      nacc = 0; nissued = 0; ndone = 0; done_cyc = -1; first_v = -1; last_hs = -1;
      pv = 0; pr = 0; pd = 0; pl = 0;

      @(posedge clk); #1;
      start = 1'b1; base = ADDR_W'(b); cnt = CNT_W'(c); bus.out_ready = ready_for(mode, 0);
      @(negedge clk);
      chk("busy_c0", busy, 0);

      for (int cyc = 1; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == inj_cyc);
         if (cyc == inj_cyc) begin
            base = ADDR_W'($urandom);
            cnt  = CNT_W'($urandom_range(1, 16));
         end
         bus.out_ready = ready_for(mode, cyc);
         @(negedge clk);
         hs = bus.out_valid && bus.out_ready;
         if (pv && !pr) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, pd);
            chk("hold_last", bus.out_last, pl);
         end
         if (bus.mem_renb) begin
            chk("addrb", bus.mem_addrb, (b + nissued) % DEPTH);
            outstanding = nissued - nacc - int'(hs);
            chk("credit", outstanding < 2, 1);
            nissued++;
         end else begin
            chk("addrb_idle", bus.mem_addrb, 0);
         end
         if (bus.out_valid && first_v < 0) first_v = cyc;
         if (hs) begin
            if (nacc < total) begin
               chk("data", bus.out_data, exp_q[nacc]);
               chk("last", bus.out_last, nacc == total - 1);
            end else begin
               chk("extra_byte", nacc, total);
            end
            last_hs = cyc;
            nacc++;
         end
         chk("busy", busy, (c != 0) && (done_cyc < 0));
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
         if (abort_after >= 0 && nacc == abort_after) break;
         if (done_cyc >= 0) break;
      end
      start = 1'b0;

      if (abort_after >= 0) begin
         chk("abort_reached", nacc, abort_after);
         @(posedge clk); #1;
         rst = 1'b1; bus.out_ready = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0; bus.out_ready = 1'b1;
         @(negedge clk);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_renb", bus.mem_renb, 0);
         chk("rst_addrb", bus.mem_addrb, 0);
         chk("rst_valid", bus.out_valid, 0);
         chk("rst_last", bus.out_last, 0);
         chk("rst_data", bus.out_data, 0);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
            chk("rst_no_valid", bus.out_valid, 0);
         end
      end else begin
         chk("bytes_out", nacc, total);
         chk("reads", nissued, c);
         chk("done_pulses", ndone, 1);
         if (total > 0) chk("done_after_last", done_cyc, last_hs + 1);
         else           chk("done_cyc_zero", done_cyc, 1);
         if (mode == 0 && total > 0) begin
            chk("first_valid", first_v, 3);
            chk("done_cyc", done_cyc, total + 3);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base = '0; cnt = '0; bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h12; mem[1] = 8'h1D; mem[2] = 8'h1D; mem[3] = 8'h1B;
      mem[14] = 8'hA0; mem[15] = 8'hA1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_renb", bus.mem_renb, 0);
      chk("reset_addrb", bus.mem_addrb, 0);
      chk("reset_valid", bus.out_valid, 0);
      chk("reset_last", bus.out_last, 0);
      chk("reset_data", bus.out_data, 0);

      run_xfer(0, 4, 0, -1, -1);
      run_xfer(0, 4, 1, -1, -1);
      run_xfer(14, 4, 0, -1, -1);
      run_xfer(0, 0, 0, -1, -1);
      run_xfer(0, 4, 0, -1, 2);
      run_xfer(2, 2, 0, -1, -1);
      run_xfer(0, 16, 0, 5, -1);
      run_xfer(0, 16, 2, 9, -1);

      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
         run_xfer($urandom % DEPTH, $urandom_range(0, 16), $urandom % 3,
                  ($urandom % 2) ? $urandom_range(2, 10) : -1, -1);
      end

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_done", done, 0);
         chk("idle_valid", bus.out_valid, 0);
         chk("idle_renb", bus.mem_renb, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
